// File: rtl/multi_tone_gen.sv
// Multi-channel square-wave tone generator: per-channel dividers with steady,
// siren and burst modes, OR-mixed onto one registered speaker pin.
module multi_tone_gen #(
    parameter int NUM_CH = 4,
    parameter int DIV_W  = 16,
    parameter int LEN_W  = 12,
    parameter int ALT_W  = 24,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [1:0]        wr_mode,
    input  logic [DIV_W-1:0]  wr_hp,
    input  logic [LEN_W-1:0]  wr_len,
    output logic [NUM_CH-1:0] tone_out,
    output logic [NUM_CH-1:0] busy,
    output logic [NUM_CH-1:0] done,
    output logic              speaker
);

    typedef enum logic [1:0] {
        M_OFF    = 2'b00,
        M_STEADY = 2'b01,
        M_SIREN  = 2'b10,
        M_BURST  = 2'b11
    } mode_e;

    mode_e             mode_q [NUM_CH];
    mode_e             mode_d [NUM_CH];
    logic [DIV_W-1:0]  hp_q   [NUM_CH];
    logic [DIV_W-1:0]  hp_d   [NUM_CH];
    logic [DIV_W-1:0]  cnt_q  [NUM_CH];
    logic [DIV_W-1:0]  cnt_d  [NUM_CH];
    logic [LEN_W-1:0]  len_q  [NUM_CH];
    logic [LEN_W-1:0]  len_d  [NUM_CH];
    logic [NUM_CH-1:0] tone_q, tone_d;
    logic [NUM_CH-1:0] done_q, done_d;
    logic [ALT_W-1:0]  alt_q, alt_d;
    logic              spk_q, spk_d;

    // Low siren phase halves the period, clamped so it never reaches zero.
    function automatic logic [DIV_W-1:0] half_period(input mode_e mode,
                                                     input logic [DIV_W-1:0] hp,
                                                     input logic phase_hi);
        logic [DIV_W-1:0] h;
        h = hp >> 1;
        if (mode != M_SIREN || phase_hi) return hp;
        if (h == '0) return DIV_W'(1);
        return h;
    endfunction

    always_comb begin
        alt_d  = alt_q + ALT_W'(1);
        spk_d  = |tone_q;
        tone_d = tone_q;
        done_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            mode_d[c] = mode_q[c];
            hp_d[c]   = hp_q[c];
            cnt_d[c]  = cnt_q[c];
            len_d[c]  = len_q[c];
            if (wr_en && int'(wr_ch) == c) begin
                // A write wins over any toggle event falling on the same edge.
                if (wr_hp == '0 || (mode_e'(wr_mode) == M_BURST && wr_len == '0))
                    mode_d[c] = M_OFF;
                else
                    mode_d[c] = mode_e'(wr_mode);
                hp_d[c]   = wr_hp;
                len_d[c]  = wr_len;
                cnt_d[c]  = wr_hp - DIV_W'(1);
                tone_d[c] = 1'b0;
            end else if (mode_q[c] != M_OFF) begin
                if (cnt_q[c] != '0) begin
                    cnt_d[c] = cnt_q[c] - DIV_W'(1);
                end else begin
                    cnt_d[c] = half_period(mode_q[c], hp_q[c], alt_q[ALT_W-1]) - DIV_W'(1);
                    if (mode_q[c] == M_BURST) begin
                        if (len_q[c] > LEN_W'(1)) begin
                            tone_d[c] = ~tone_q[c];
                            len_d[c]  = len_q[c] - LEN_W'(1);
                        end else begin
                            tone_d[c] = 1'b0;
                            mode_d[c] = M_OFF;
                            len_d[c]  = '0;
                            done_d[c] = 1'b1;
                        end
                    end else begin
                        tone_d[c] = ~tone_q[c];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alt_q  <= '0;
            spk_q  <= 1'b0;
            tone_q <= '0;
            done_q <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                mode_q[c] <= M_OFF;
                hp_q[c]   <= '0;
                cnt_q[c]  <= '0;
                len_q[c]  <= '0;
            end
        end else begin
            alt_q  <= alt_d;
            spk_q  <= spk_d;
            tone_q <= tone_d;
            done_q <= done_d;
            for (int c = 0; c < NUM_CH; c++) begin
                mode_q[c] <= mode_d[c];
                hp_q[c]   <= hp_d[c];
                cnt_q[c]  <= cnt_d[c];
                len_q[c]  <= len_d[c];
            end
        end
    end

    always_comb begin
        busy = '0;
        for (int c = 0; c < NUM_CH; c++)
            busy[c] = (mode_q[c] != M_OFF);
    end

    assign tone_out = tone_q;
    assign done     = done_q;
    assign speaker  = spk_q;

endmodule
